// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The optional per-requester beat counters are enabled with FIFO_WR_ARB_STATS_EN.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotate-priority picker: first set req bit searching upward from last_id+1, with wrap.
module fifo_wr_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_id,
  output logic            valid,
  output logic [IW-1:0]   pick_id
);

  int idx;

  // Walk from the farthest offset down so the nearest candidate is assigned last and wins.
  always_comb begin
    valid   = 1'b0;
    pick_id = '0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_id) + k) % NREQ;
      if (req[idx]) begin
        valid   = 1'b1;
        pick_id = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter for the FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add per-requester saturating beat counters (stat_sel/stat_cnt).
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         gnt,
  output logic                    fifo_wr_en,
  output logic [DW-1:0]           fifo_din,
  input  logic                    fifo_full,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] cur_id
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic [$clog2(NREQ)-1:0] stat_sel,
  output logic [STAT_W-1:0]       stat_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  arb_state_t      state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [IW-1:0]   cur_id_reg, cur_id_next;
  logic [IW-1:0]   last_id_reg, last_id_next;
  logic [3:0]      beat_cnt_reg, beat_cnt_next;

  logic [DW-1:0]   data_slice [NREQ];
  logic            granted, beat, burst_end;
  logic            pick_valid;
  logic [IW-1:0]   pick_id;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_slice[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  fifo_wr_arb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .last_id (last_id_reg),
    .valid   (pick_valid),
    .pick_id (pick_id)
  );

  assign granted = (state_reg == GRANT);
  assign beat    = granted && req[cur_id_reg] && !fifo_full;
  // A dropped request ends the burst even while the FIFO is stalling us.
  assign burst_end = (beat && (req_last[cur_id_reg] || beat_cnt_reg == LAST_BEAT))
                   || !req[cur_id_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      cur_id_reg   <= '0;
      last_id_reg  <= IW'(NREQ - 1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      cur_id_reg   <= cur_id_next;
      last_id_reg  <= last_id_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    cur_id_next   = cur_id_reg;
    last_id_next  = last_id_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next    = GRANT;
          gnt_next      = {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
          cur_id_next   = pick_id;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (beat) beat_cnt_next = beat_cnt_reg + 4'd1;
        if (burst_end) begin
          state_next   = IDLE;
          gnt_next     = '0;
          last_id_next = cur_id_reg;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign gnt        = gnt_reg;
  assign busy       = granted;
  assign cur_id     = cur_id_reg;
  assign fifo_wr_en = beat;
  assign fifo_din   = granted ? data_slice[cur_id_reg] : '0;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_arr [NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (beat && cur_id_reg == IW'(gi) && cnt_reg != STAT_SAT) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign stat_arr[gi] = cnt_reg;
    end
  endgenerate

  assign stat_cnt = stat_arr[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NREQ=4, DW=8, MAX_BURST=4).
// Build with FIFO_WR_ARB_STATS_EN defined to also exercise the beat counters.
module tb_fifo_wr_arbiter;
  import fifo_wr_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   gnt;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
  logic              fifo_full = 1'b0;
  logic              busy;
  logic [1:0]        cur_id;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [1:0]        stat_sel = '0;
  logic [STAT_W-1:0] stat_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .cur_id     (cur_id)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] data_of(int i);
    return 8'(8'h31 + 8'(17 * i));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({8'(id), data_of(id)});
  endtask

  // Write monitor: every strobe must match the next expected (id, data) pair.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      logic [15:0] e;
      $display("wr id=%0d din=%0h full=%0b", cur_id, fifo_din, fifo_full);
      check("wr_while_full", {31'd0, fifo_full}, 32'd0);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {30'd0, cur_id}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_id_data", {16'd0, 6'd0, cur_id, fifo_din}, {16'd0, e});
      end
    end
  end

  function automatic logic [3:0] fair_gnt(int t);
    if (t == 0 || ((t - 1) % 5) == 4) return 4'b0000;
    return 4'(1 << (((t - 1) / 5) % 4));
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = data_of(i);

    // Reset state
    @(negedge clk);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("rst_cur_id", {30'd0, cur_id}, 32'd0);
    check("rst_din", {24'd0, fifo_din}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fairness: grant order 0,1,2,3,0 with 4 beats and a one-cycle bubble each
    push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
    req = 4'hF;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      check($sformatf("fair_gnt_t%0d", t), {28'd0, gnt}, {28'd0, fair_gnt(t)});
      check($sformatf("fair_busy_t%0d", t), {31'd0, busy}, {31'd0, |fair_gnt(t)});
      tick();
    end
    req = '0;
    tick();

    // Packet end: requester 2 ends on its second beat
    push(2, 2);
    req = 4'b0100;
    @(negedge clk); check("pkt_gnt_t0", {28'd0, gnt}, 32'd0);
    tick();
    @(negedge clk); check("pkt_gnt_t1", {28'd0, gnt}, 32'h4);
    check("pkt_cur_id", {30'd0, cur_id}, 32'd2);
    tick();
    req_last = 4'b0100;
    @(negedge clk); check("pkt_wr_t2", {31'd0, fifo_wr_en}, 32'd1);
    tick();
    req = '0; req_last = '0;
    @(negedge clk); check("pkt_gnt_t3", {28'd0, gnt}, 32'd0);
    check("pkt_din_idle", {24'd0, fifo_din}, 32'd0);
    tick();

    // Backpressure: 3 stall cycles after 2 beats, still 4 beats total
    push(3, 4);
    req = 4'b1000;
    tick(); tick(); tick();
    fifo_full = 1'b1;
    for (int t = 3; t < 6; t++) begin
      @(negedge clk);
      check($sformatf("bp_gnt_t%0d", t), {28'd0, gnt}, 32'h8);
      check($sformatf("bp_wr_t%0d", t), {31'd0, fifo_wr_en}, 32'd0);
      check($sformatf("bp_din_t%0d", t), {24'd0, fifo_din}, {24'd0, data_of(3)});
      tick();
    end
    fifo_full = 1'b0;
    tick();
    @(negedge clk); check("bp_gnt_t7", {28'd0, gnt}, 32'h8);
    tick();
    @(negedge clk); check("bp_gnt_t8", {28'd0, gnt}, 32'd0);
    req = '0;
    tick();

    // Withdrawal: requester 1 drops after one beat, requester 2 follows
    push(1, 1); push(2, 1);
    req = 4'b0110;
    tick();
    @(negedge clk); check("wd_gnt_t1", {28'd0, gnt}, 32'h2);
    tick();
    req = 4'b0100;
    @(negedge clk); check("wd_wr_t2", {31'd0, fifo_wr_en}, 32'd0);
    tick();
    @(negedge clk); check("wd_gnt_t3", {28'd0, gnt}, 32'd0);
    tick();
    @(negedge clk); check("wd_gnt_t4", {28'd0, gnt}, 32'h4);
    tick();
    req = '0;
    tick();

    // Reset mid-burst aborts immediately; requester 0 wins first afterwards
    push(3, 2);
    req = 4'hF;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    push(0, 1);
    tick();
    @(negedge clk); check("post_rst_gnt", {28'd0, gnt}, 32'h1);
    check("post_rst_cur_id", {30'd0, cur_id}, 32'd0);
    tick();
    req = '0;
    tick();

    // Three back-to-back bursts from requester 3
    push(3, 12);
    req = 4'b1000;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (t == 3) begin
        @(negedge clk); check("b3_gnt_end", {28'd0, gnt}, 32'h8);
      end
      if (t == 4) begin
        @(negedge clk); check("b3_bubble", {28'd0, gnt}, 32'd0);
      end
      if (t == 5) begin
        @(negedge clk); check("b3_regrant", {28'd0, gnt}, 32'h8);
      end
    end
    req = '0;
    tick(); tick();

`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel = 2'd3;
    #1; check("stat_cnt_3", {16'd0, stat_cnt}, 32'd12);
    stat_sel = 2'd0;
    #1; check("stat_cnt_0", {16'd0, stat_cnt}, 32'd1);
`endif

    check("sb_leftover", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the 8-entry FIFO among NREQ requesters. Grants are burst-locked: a requester keeps the port until it signals end of packet, runs out of burst budget, or withdraws its request. The block sits directly in front of the FIFO's write side. It drives the FIFO's write enable and data from the granted requester and honours the FIFO's full flag as backpressure.

## Interface
Parameters:
- NREQ, default 4: number of requesters; range 2..8.
- DW, default 1: data width; matches the FIFO data width.
- MAX_BURST, default 4: maximum beats per grant; range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, NREQ: per-requester write request, level.
- req_data, input, NREQ*DW: per-requester data; slice i is bits [i*DW +: DW].
- req_last, input, NREQ: marks the final beat of a requester's packet.
- gnt, output, NREQ: registered one-hot grant; all zeros when idle.
- fifo_wr_en, output, 1: write strobe to the FIFO.
- fifo_din, output, DW: data to the FIFO.
- fifo_full, input, 1: FIFO full flag.
- busy, output, 1: high while a grant is held.
- cur_id, output, $clog2(NREQ): index of the granted requester; holds its last value when idle.

## Operation
- There are two states, IDLE and GRANT.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward (with wrap) from last_id+1.
  - Next cycle: state becomes GRANT, gnt is one-hot at the picked index, cur_id equals that index, and beat_cnt is cleared.
- GRANT, beat condition: a beat occurs when req[cur_id] && !fifo_full.
  - fifo_wr_en = beat, combinational from registered gnt/cur_id plus live req and fifo_full.
  - fifo_din = req_data slice cur_id. It is driven in GRANT even when no beat occurs, and is 0 in IDLE.
  - Each beat increments beat_cnt, which is 4 bits wide.
- GRANT, end of burst (go to IDLE, clear gnt, set last_id = cur_id) when any of these holds:
  - A beat occurs with req_last[cur_id] high.
  - A beat occurs with beat_cnt == MAX_BURST-1.
  - req[cur_id] is low, regardless of fifo_full.
- Both beat-ending conditions in the same cycle count as one end; the burst still ends after a single beat.
- fifo_full high in GRANT:
  - No beat occurs, beat_cnt holds, and the grant is held.
  - Stall cycles do not consume burst budget.
- Requests from non-granted requesters are ignored until the next arbitration.
- Idle bubble: there is always exactly one IDLE cycle between consecutive grants.
- The FIFO's own full check remains in force; the arbiter never asserts fifo_wr_en while fifo_full is high.
- Reset values, asynchronous on rst_n low:
  - state = IDLE, gnt = 0, busy = 0, cur_id = 0, beat_cnt = 0, last_id = NREQ-1 (so requester 0 wins first).
  - fifo_wr_en = 0 and fifo_din = 0 follow from IDLE.
- Reset mid-burst aborts the grant immediately. No write is issued while rst_n is low.

## Timing
- req[i] rising in IDLE at cycle 0 gives gnt[i]=1 and busy=1 at cycle 1. The first possible fifo_wr_en is in cycle 1.
- With fifo_full low and req held, beats occur on consecutive cycles.
- The burst-ending beat is at cycle k, and gnt is 0 at cycle k+1. The earliest next grant is at cycle k+2.
- A MAX_BURST burst with no stalls occupies MAX_BURST+1 cycles including the bubble.

## Configuration
- Macro FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds a 16-bit saturating beat counter per requester, incremented on each of that requester's beats and held at 16'hFFFF once reached.
  - Adds ports stat_sel (input, $clog2(NREQ)) and stat_cnt (output, 16), where stat_cnt is the combinational read of counter stat_sel.
  - Counters reset to 0 on rst_n.
- Undefined: no counters and no stat ports; the arbitration behaviour is identical either way.

## Structure
- Package fifo_wr_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the stat counter width constant (16);
  - the saturation value.
- Sub-module fifo_wr_arb_rr_pick:
  - combinational rotate-priority picker;
  - inputs: req vector and last_id;
  - outputs: a valid flag and the picked index.

## Test plan
- Reset: pulse rst_n low mid-burst -> gnt=0, fifo_wr_en=0, and busy=0 immediately; after release, req=4'b1111 grants requester 0 first.
- Fairness, NREQ=4, all req high, no req_last, fifo_full=0 -> grant order 0,1,2,3,0. Each grant carries exactly 4 beats and is followed by a 1-cycle bubble.
- Packet end: req[2] with req_last on beat 2 -> 2 writes of req_data slice 2, then gnt=0 in the next cycle.
- Backpressure: fifo_full high for 3 cycles mid-burst -> no fifo_wr_en during the stall, grant held, and 4 beats total still delivered.
- Withdrawal: req[1] dropped after 1 beat -> grant released the next cycle and requester 2 granted one cycle later.
- With FIFO_WR_ARB_STATS_EN defined: 3 bursts of 4 beats from requester 3 and stat_sel=3 -> stat_cnt=12.
